// File: rtl/viterbi_pkg.sv
// Shared constants and types for the K=7 rate-1/2 convolutional code (171/133 octal)
// used by the encoder and the Viterbi decoder datapath.
package viterbi_pkg;

  localparam int K          = 7;
  localparam int SR_W       = K - 1;
  localparam int NUM_STATES = 64;
  localparam int TAIL_LEN   = K - 1;

  localparam logic [K-1:0] G0_OCT = 7'o171;
  localparam logic [K-1:0] G1_OCT = 7'o133;

  // bit0 = G0 parity, bit1 = G1 parity, same order as the decoder's rx_pair
  typedef logic [1:0] code_pair_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } enc_state_e;

  function automatic logic gen_parity(input logic [K-1:0] w, input logic [K-1:0] g);
    return ^(w & g);
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Combinational encode step: (sr, b) -> code pair and next shift-register contents.
// The window is {b, sr}; sr[5] holds the most recent previous bit.
module conv_enc_core
  import viterbi_pkg::*;
(
  input  logic [SR_W-1:0] sr,
  input  logic            b,
  output code_pair_t      pair,
  output logic [SR_W-1:0] sr_next
);

  logic [K-1:0] w;

  always_comb begin
    w       = {b, sr};
    pair    = {gen_parity(w, G1_OCT), gen_parity(w, G0_OCT)};
    sr_next = w[K-1:1];
  end

endmodule

// File: rtl/conv_encoder_k7.sv
// Rate-1/2 K=7 convolutional encoder with a single-entry output register.
// Define CONV_ENCODER_K7_TAIL_EN to append six zero tail bits to every frame.
//
// state | meaning
// IDLE  | no frame in progress, first bit of the next frame accepted combinationally
// DATA  | accepting information bits of the current frame
// TAIL  | flushing six zero bits so the trellis ends in state 0
module conv_encoder_k7
  import viterbi_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output code_pair_t out_pair,
  output logic       out_last,
  output logic       busy
);

  enc_state_e      state_q, state_d;
  logic [SR_W-1:0] sr_q, sr_d;
  logic [15:0]     bcnt_q, bcnt_d;
  logic [2:0]      tcnt_q, tcnt_d;
  logic            out_valid_q, out_valid_d;
  code_pair_t      out_pair_q, out_pair_d;
  logic            out_last_q, out_last_d;

  logic            adv;
  logic            accept;
  logic            enc_step;
  logic            enc_b;
  logic [15:0]     bcnt_inc;
  code_pair_t      enc_pair;
  logic [SR_W-1:0] enc_sr_next;

  conv_enc_core u_core (
    .sr      (sr_q),
    .b       (enc_b),
    .pair    (enc_pair),
    .sr_next (enc_sr_next)
  );

  always_comb begin
    adv      = !out_valid_q || out_ready;
    in_ready = !rst && adv && (state_q == IDLE || state_q == DATA);
    accept   = in_valid && in_ready;
    bcnt_inc = bcnt_q + 16'd1;
`ifdef CONV_ENCODER_K7_TAIL_EN
    enc_b    = (state_q == TAIL) ? 1'b0 : in_bit;
`else
    enc_b    = in_bit;
`endif
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bcnt_d      = bcnt_q;
    tcnt_d      = tcnt_q;
    out_valid_d = out_valid_q;
    out_pair_d  = out_pair_q;
    out_last_d  = out_last_q;
    enc_step    = 1'b0;

    if (adv) out_valid_d = 1'b0;

    case (state_q)
      IDLE, DATA: begin
        if (accept) begin
          enc_step = 1'b1;
          bcnt_d   = bcnt_inc;
          // bcnt is 0 in IDLE, so the same compare covers FRAME_LEN == 1
          if (bcnt_inc == 16'(FRAME_LEN)) begin
`ifdef CONV_ENCODER_K7_TAIL_EN
            state_d    = TAIL;
            tcnt_d     = 3'd0;
            out_last_d = 1'b0;
`else
            state_d    = IDLE;
            bcnt_d     = 16'd0;
            out_last_d = 1'b1;
`endif
          end else begin
            state_d    = DATA;
            out_last_d = 1'b0;
          end
        end
      end
`ifdef CONV_ENCODER_K7_TAIL_EN
      TAIL: begin
        if (adv) begin
          enc_step = 1'b1;
          tcnt_d   = tcnt_q + 3'd1;
          if (tcnt_q == 3'(TAIL_LEN - 1)) begin
            state_d    = IDLE;
            tcnt_d     = 3'd0;
            bcnt_d     = 16'd0;
            out_last_d = 1'b1;
          end else begin
            out_last_d = 1'b0;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (enc_step) begin
      out_valid_d = 1'b1;
      out_pair_d  = enc_pair;
      sr_d        = enc_sr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      bcnt_q      <= '0;
      tcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_pair_q  <= 2'b00;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bcnt_q      <= bcnt_d;
      tcnt_q      <= tcnt_d;
      out_valid_q <= out_valid_d;
      out_pair_q  <= out_pair_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pair  = out_pair_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_conv_encoder_k7.sv
// Self-checking bench for conv_encoder_k7 with FRAME_LEN = 4; follows CONV_ENCODER_K7_TAIL_EN.
module tb_conv_encoder_k7;

  localparam int FL = 4;
`ifdef CONV_ENCODER_K7_TAIL_EN
  localparam int TL = 6;
`else
  localparam int TL = 0;
`endif
  localparam int PPF = FL + TL;

  typedef struct packed {
    logic [1:0] pair;
    logic       last;
  } exp_t;

  typedef struct packed {
    logic [3:0]  bits;
    logic [19:0] pairs;
    logic [3:0]  npairs;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_bit = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [1:0] out_pair;
  logic       out_last;
  logic       busy;

  conv_encoder_k7 #(.FRAME_LEN(FL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pair  (out_pair),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         n_out = 0;
  bit         last_acc = 0;
  bit         use_model = 1;
  bit         stall_prev = 0;
  logic [1:0] prev_pair;
  logic       prev_last;
  logic [6:1] m_hist = '0;
  int         m_cnt = 0;
  exp_t       exp_q[$];
  vec_t       vecs[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: d[1] is the most recent previous bit; taps read straight off 171/133 octal.
  task automatic model_push(input logic b, input logic lst);
    exp_t e;
    e.pair[0] = b ^ m_hist[1] ^ m_hist[2] ^ m_hist[3] ^ m_hist[6];
    e.pair[1] = b ^ m_hist[2] ^ m_hist[3] ^ m_hist[5] ^ m_hist[6];
    e.last    = lst;
    m_hist    = {m_hist[5:1], b};
    if (use_model) exp_q.push_back(e);
  endtask

  task automatic model_accept(input logic b);
    m_cnt++;
    if (m_cnt == FL) begin
      model_push(b, TL == 0);
      m_cnt = 0;
      for (int t = 0; t < TL; t++) model_push(1'b0, t == TL - 1);
    end else begin
      model_push(b, 1'b0);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    last_acc = 0;
    if (!rst) begin
      if (stall_prev) begin
        chk("stall_valid_hold", 32'(out_valid), 32'd1);
        chk("stall_pair_hold", 32'(out_pair), 32'(prev_pair));
        chk("stall_last_hold", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && !out_ready) chk("no_accept_while_stalled", 32'(in_ready), 32'd0);
      stall_prev = out_valid && !out_ready;
      prev_pair  = out_pair;
      prev_last  = out_last;
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pair: got pair %0d last %0d with nothing expected (cycle %0d)",
                   out_pair, out_last, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("out_pair", 32'(out_pair), 32'(e.pair));
          chk("out_last", 32'(out_last), 32'(e.last));
        end
      end
      if (in_valid && in_ready) begin
        last_acc = 1;
        model_accept(in_bit);
      end
    end else begin
      stall_prev = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("in_ready_during_rst", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      cyc++;
    end
    rst = 1'b0;
    exp_q.delete();
    m_hist     = '0;
    m_cnt      = 0;
    stall_prev = 0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_pair", 32'(out_pair), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input bit rnd);
    int budget;
    for (int i = 0; i < n; i++) begin
      in_bit = bits[i];
      budget = 0;
      do begin
        in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        tick();
        budget++;
      end while (!last_acc && budget < 100);
      if (!last_acc) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: bit %0d not accepted within 100 cycles", i);
      end else begin
        chk("load_latency", 32'(out_valid), 32'd1);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int budget;
    budget   = 0;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && budget < 400) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      budget++;
    end
    out_ready = 1'b1;
    chk("drain_all_pairs_seen", 32'(exp_q.size()), 32'd0);
    chk("idle_after_frame", 32'(busy), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    use_model = 0;
    for (int i = 0; i < int'(v.npairs); i++) begin
      e.pair = v.pairs[2*i +: 2];
      e.last = (i == int'(v.npairs) - 1);
      exp_q.push_back(e);
    end
    send_bits({12'd0, v.bits}, FL, 0);
    drain(0);
    use_model = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n0;

    // bits[i] is the i-th bit sent; pairs[2i+:2] is the i-th pair expected (listed last..first)
`ifdef CONV_ENCODER_K7_TAIL_EN
    vecs[0] = '{bits: 4'b0001, npairs: 4'd10,
                pairs: {2'd0, 2'd0, 2'd0, 2'd3, 2'd2, 2'd0, 2'd3, 2'd3, 2'd1, 2'd3}};
    vecs[1] = '{bits: 4'b0000, npairs: 4'd10,
                pairs: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
    vecs[2] = '{bits: 4'b1011, npairs: 4'd10,
                pairs: {2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2, 2'd3}};
`else
    vecs[0] = '{bits: 4'b0001, npairs: 4'd4, pairs: {12'd0, 2'd3, 2'd3, 2'd1, 2'd3}};
    vecs[1] = '{bits: 4'b0000, npairs: 4'd4, pairs: {12'd0, 2'd0, 2'd3, 2'd2, 2'd0}};
    vecs[2] = '{bits: 4'b1011, npairs: 4'd4, pairs: {12'd0, 2'd3, 2'd2, 2'd2, 2'd3}};
`endif

    do_reset(2);

    // Impulse, zeros (trellis carry-over in the streaming build), mixed data
    for (int v = 0; v < 3; v++) run_vec(vecs[v]);

    // Back-to-back frames with in_valid held high: no bubble at the frame boundary
    c0 = cyc;
    send_bits(16'h00BB, 2 * FL, 0);
    chk("b2b_cycles", 32'(cyc - c0), 32'(2 * FL + TL));
    drain(0);

    // Random data with random in_valid and out_ready backpressure
    for (int f = 0; f < 4; f++) begin
      send_bits(16'($urandom), FL, 1);
      drain(1);
    end

    // Five-cycle input gap mid-frame
    n0 = n_out;
    send_bits(16'h0002, 2, 0);
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("gap_no_pair", 32'(out_valid), 32'd0);
      chk("gap_busy", 32'(busy), 32'd1);
    end
    send_bits(16'h0003, FL - 2, 0);
    drain(0);
    chk("gap_pair_count", 32'(n_out - n0), 32'(PPF));

    // Mid-frame reset after 3 bits and 2 emitted pairs, then a fresh impulse frame
    n0 = n_out;
    send_bits(16'h0005, 3, 0);
    chk("pairs_before_rst", 32'(n_out - n0), 32'd2);
    chk("busy_before_rst", 32'(busy), 32'd1);
    do_reset(1);
    n0 = n_out;
    run_vec(vecs[0]);
    chk("post_rst_pair_count", 32'(n_out - n0), 32'(PPF));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
